// File: rtl/axi4_pkg.sv
// AXI4 shared types for the SRAM subordinate: widths, response/burst
// encodings, per-channel manager/subordinate structs and a response helper.
package axi4_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef struct packed {
        logic                  valid;
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        burst_e                burst;
    } aw_m;

    typedef aw_m ar_m;

    typedef struct packed {
        logic                  valid;
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } w_m;

    typedef struct packed { logic ready; } b_m;
    typedef struct packed { logic ready; } r_m;
    typedef struct packed { logic ready; } aw_s;
    typedef struct packed { logic ready; } w_s;
    typedef struct packed { logic ready; } ar_s;

    typedef struct packed {
        logic                valid;
        logic [AXI_ID_W-1:0] id;
        resp_e               resp;
    } b_s;

    typedef struct packed {
        logic                  valid;
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        resp_e                 resp;
        logic                  last;
    } r_s;

    // Decode error outranks slave error; otherwise OKAY.
    function automatic resp_e resp_select(input logic decerr, input logic slverr);
        resp_e r;
        if (decerr) begin
            r = RESP_DECERR;
        end else if (slverr) begin
            r = RESP_SLVERR;
        end else begin
            r = RESP_OKAY;
        end
        return r;
    endfunction

endpackage

// File: rtl/riscv_sram_1r1w.sv
// Byte-enabled word memory: one registered read port, one write port.
// A read and a write to the same word in one cycle return the old data.
module riscv_sram_1r1w #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Write port: update only the enabled byte lanes; array is never reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (wr_be[i]) begin
                    mem_r[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Read port register: captures pre-write contents, holds when not enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/riscv_axi_sram_sub.sv
// AXI4 subordinate in front of a word-addressed SRAM. Independent read and
// write FSMs; INCR bursts wrap at the end of the array.
// Optional: define AXI_SRAM_BOUNDS_CHECK_EN to answer DECERR for addresses
// with nonzero bits above the word-index range.
module riscv_axi_sram_sub
    import axi4_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 2,
    parameter int MAX_LEN  = 15
) (
    input  logic clock,
    input  logic reset,
    input  aw_m  AXI_AW_M,
    input  w_m   AXI_W_M,
    input  b_m   AXI_B_M,
    input  ar_m  AXI_AR_M,
    input  r_m   AXI_R_M,
    output aw_s  AXI_AW_S,
    output w_s   AXI_W_S,
    output b_s   AXI_B_S,
    output ar_s  AXI_AR_S,
    output r_s   AXI_R_S
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AXI_LEN_W-1:0] MAX_LEN_L = AXI_LEN_W'(MAX_LEN);

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] { W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2 } wr_state_e;
    typedef enum logic       { R_IDLE = 1'b0, R_DATA = 1'b1 } rd_state_e;

    function automatic logic [AXI_LEN_W-1:0] sat_len(input logic [AXI_LEN_W-1:0] len);
        return (len > MAX_LEN_L) ? MAX_LEN_L : len;
    endfunction

    // Write channel state
    wr_state_e             wr_state_r, wr_state_s;
    idx_t                  wr_idx_r;
    logic [AXI_LEN_W-1:0]  wr_len_r, wr_beat_r;
    logic [AXI_ID_W-1:0]   wr_id_r, bid_r;
    logic                  wr_err_r, wr_dec_r;
    logic                  awready_r, wready_r, bvalid_r;
    resp_e                 bresp_r;

    // Read channel state
    rd_state_e             rd_state_r, rd_state_s;
    idx_t                  rd_idx_r, mem_rd_idx_s;
    logic [AXI_LEN_W-1:0]  rd_len_r, rd_beat_r;
    logic [AXI_ID_W-1:0]   rid_r;
    logic                  rd_dec_r, arready_r, rvalid_r, rlast_r;
    resp_e                 rresp_r;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic w_is_last_s, w_bad_last_s, r_is_last_s, mem_rd_en_s;
    logic aw_dec_s, ar_dec_s, unused_ok_s;
    logic [AXI_DATA_W-1:0] mem_rd_data_s;

    assign aw_hs_s      = (wr_state_r == W_IDLE) && AXI_AW_M.valid;
    assign w_hs_s       = (wr_state_r == W_DATA) && AXI_W_M.valid;
    assign b_hs_s       = (wr_state_r == W_RESP) && AXI_B_M.ready;
    assign w_is_last_s  = (wr_beat_r == wr_len_r);
    assign w_bad_last_s = (AXI_W_M.last != w_is_last_s);
    assign ar_hs_s      = (rd_state_r == R_IDLE) && AXI_AR_M.valid;
    assign r_hs_s       = (rd_state_r == R_DATA) && AXI_R_M.ready;
    assign r_is_last_s  = (rd_beat_r == rd_len_r);

`ifdef AXI_SRAM_BOUNDS_CHECK_EN
    assign aw_dec_s = |AXI_AW_M.addr[AXI_ADDR_W-1:ADDR_LSB+IDX_W];
    assign ar_dec_s = |AXI_AR_M.addr[AXI_ADDR_W-1:ADDR_LSB+IDX_W];
`else
    assign aw_dec_s = 1'b0;
    assign ar_dec_s = 1'b0;
`endif

    // Burst type and address bits outside the index are intentionally ignored.
    assign unused_ok_s = ^{AXI_AW_M.burst, AXI_AR_M.burst, AXI_AW_M.addr, AXI_AR_M.addr};

    // Write FSM next-state logic.
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE:  if (aw_hs_s) wr_state_s = W_DATA; else wr_state_s = W_IDLE;
            W_DATA:  if (w_hs_s && w_is_last_s) wr_state_s = W_RESP; else wr_state_s = W_DATA;
            W_RESP:  if (b_hs_s) wr_state_s = W_IDLE; else wr_state_s = W_RESP;
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Write FSM state, burst bookkeeping and registered AW/W/B outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_state_r <= W_IDLE;
            awready_r  <= 1'b1;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bid_r      <= '0;
            bresp_r    <= RESP_OKAY;
            wr_idx_r   <= '0;
            wr_len_r   <= '0;
            wr_beat_r  <= '0;
            wr_id_r    <= '0;
            wr_err_r   <= 1'b0;
            wr_dec_r   <= 1'b0;
        end else begin
            wr_state_r <= wr_state_s;
            awready_r  <= (wr_state_s == W_IDLE);
            wready_r   <= (wr_state_s == W_DATA);
            bvalid_r   <= (wr_state_s == W_RESP);
            if (aw_hs_s) begin
                wr_id_r   <= AXI_AW_M.id;
                wr_idx_r  <= AXI_AW_M.addr[ADDR_LSB +: IDX_W];
                wr_len_r  <= sat_len(AXI_AW_M.len);
                wr_beat_r <= '0;
                wr_err_r  <= (AXI_AW_M.len > MAX_LEN_L);
                wr_dec_r  <= aw_dec_s;
            end
            if (w_hs_s) begin
                wr_idx_r  <= wr_idx_r + idx_t'(1);
                wr_beat_r <= wr_beat_r + 8'd1;
                if (w_bad_last_s) begin
                    wr_err_r <= 1'b1;
                end
                if (w_is_last_s) begin
                    bid_r   <= wr_id_r;
                    bresp_r <= resp_select(wr_dec_r, wr_err_r | w_bad_last_s);
                end
            end
        end
    end

    // Read FSM next-state logic.
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE:  if (ar_hs_s) rd_state_s = R_DATA; else rd_state_s = R_IDLE;
            R_DATA:  if (r_hs_s && r_is_last_s) rd_state_s = R_IDLE; else rd_state_s = R_DATA;
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Memory read request: fetch the first beat at AR, then prefetch on each accepted beat.
    always_comb begin
        mem_rd_en_s  = ar_hs_s || (r_hs_s && !r_is_last_s);
        mem_rd_idx_s = rd_idx_r + idx_t'(1);
        if (ar_hs_s) begin
            mem_rd_idx_s = AXI_AR_M.addr[ADDR_LSB +: IDX_W];
        end else begin
            mem_rd_idx_s = rd_idx_r + idx_t'(1);
        end
    end

    // Read FSM state, beat tracking and registered AR/R outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_state_r <= R_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rid_r      <= '0;
            rresp_r    <= RESP_OKAY;
            rd_idx_r   <= '0;
            rd_len_r   <= '0;
            rd_beat_r  <= '0;
            rd_dec_r   <= 1'b0;
        end else begin
            rd_state_r <= rd_state_s;
            arready_r  <= (rd_state_s == R_IDLE);
            rvalid_r   <= (rd_state_s == R_DATA);
            if (ar_hs_s) begin
                rid_r     <= AXI_AR_M.id;
                rd_idx_r  <= AXI_AR_M.addr[ADDR_LSB +: IDX_W];
                rd_len_r  <= sat_len(AXI_AR_M.len);
                rd_beat_r <= '0;
                rd_dec_r  <= ar_dec_s;
                rlast_r   <= (sat_len(AXI_AR_M.len) == 8'd0);
                rresp_r   <= resp_select(ar_dec_s, AXI_AR_M.len > MAX_LEN_L);
            end
            if (r_hs_s) begin
                rd_idx_r  <= rd_idx_r + idx_t'(1);
                rd_beat_r <= rd_beat_r + 8'd1;
                rlast_r   <= !r_is_last_s && ((rd_beat_r + 8'd1) == rd_len_r);
            end
        end
    end

    riscv_sram_1r1w #(
        .DEPTH  (DEPTH),
        .DATA_W (AXI_DATA_W),
        .IDX_W  (IDX_W)
    ) u_sram (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (mem_rd_en_s),
        .rd_idx  (mem_rd_idx_s),
        .rd_data (mem_rd_data_s),
        .wr_en   (w_hs_s && !wr_dec_r),
        .wr_idx  (wr_idx_r),
        .wr_be   (AXI_W_M.strb),
        .wr_data (AXI_W_M.data)
    );

    assign AXI_AW_S.ready = awready_r;
    assign AXI_W_S.ready  = wready_r;
    assign AXI_B_S.valid  = bvalid_r;
    assign AXI_B_S.id     = bid_r;
    assign AXI_B_S.resp   = bresp_r;
    assign AXI_AR_S.ready = arready_r;
    assign AXI_R_S.valid  = rvalid_r;
    assign AXI_R_S.id     = rid_r;
    assign AXI_R_S.data   = rd_dec_r ? '0 : mem_rd_data_s;
    assign AXI_R_S.resp   = rresp_r;
    assign AXI_R_S.last   = rlast_r;

endmodule

// File: tb/tb_riscv_axi_sram_sub.sv
// Directed bench for riscv_axi_sram_sub: single/partial writes, wrapping
// bursts, stalled reads, WLAST and length errors, read-before-write,
// optional bounds check and reset in mid-burst.
module tb_riscv_axi_sram_sub;
    import axi4_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    aw_m axi_aw_m;
    w_m  axi_w_m;
    b_m  axi_b_m;
    ar_m axi_ar_m;
    r_m  axi_r_m;
    aw_s axi_aw_s;
    w_s  axi_w_s;
    b_s  axi_b_s;
    ar_s axi_ar_s;
    r_s  axi_r_s;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wbuf [32];
    logic [31:0] rbuf [32];
    logic [31:0] rlast_mask;
    int          rcount;
    logic [1:0]  r_resp;
    logic [3:0]  r_id;
    logic        r_first;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        b_imm;

    riscv_axi_sram_sub #(.DEPTH(1024), .ADDR_LSB(2), .MAX_LEN(15)) dut (
        .clock    (clock),
        .reset    (reset),
        .AXI_AW_M (axi_aw_m),
        .AXI_W_M  (axi_w_m),
        .AXI_B_M  (axi_b_m),
        .AXI_AR_M (axi_ar_m),
        .AXI_R_M  (axi_r_m),
        .AXI_AW_S (axi_aw_s),
        .AXI_W_S  (axi_w_s),
        .AXI_B_S  (axi_b_s),
        .AXI_AR_S (axi_ar_s),
        .AXI_R_S  (axi_r_s)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        axi_aw_m.valid = 1'b1;
        axi_aw_m.id    = id;
        axi_aw_m.addr  = addr;
        axi_aw_m.len   = len;
        axi_aw_m.burst = BURST_INCR;
        while (!axi_aw_s.ready && n < 50) begin tick(); n++; end
        if (n >= 50) check_val("aw_timeout", 32'd0, 32'd1);
        tick();
        axi_aw_m.valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        axi_w_m.valid = 1'b1;
        axi_w_m.data  = data;
        axi_w_m.strb  = strb;
        axi_w_m.last  = last;
        while (!axi_w_s.ready && n < 50) begin tick(); n++; end
        if (n >= 50) check_val("w_timeout", 32'd0, 32'd1);
        tick();
        axi_w_m.valid = 1'b0;
    endtask

    task automatic recv_b();
        int n = 0;
        axi_b_m.ready = 1'b1;
        while (!axi_b_s.valid && n < 50) begin tick(); n++; end
        if (n >= 50) check_val("b_timeout", 32'd0, 32'd1);
        b_resp = axi_b_s.resp;
        b_id   = axi_b_s.id;
        tick();
        axi_b_m.ready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input int nbeats, input logic [3:0] strb, input int last_at);
        send_aw(addr, id, len);
        for (int b = 0; b < nbeats; b++) send_w(wbuf[b], strb, (b == last_at));
        b_imm = axi_b_s.valid;
        recv_b();
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [3:0] pat);
        int n = 0;
        int cyc = 0;
        logic done = 1'b0;
        logic held = 1'b0;
        logic [31:0] h_data;
        logic [3:0]  h_id;
        logic        h_last;
        rcount = 0;
        rlast_mask = '0;
        axi_r_m.ready  = 1'b0;
        axi_ar_m.valid = 1'b1;
        axi_ar_m.id    = id;
        axi_ar_m.addr  = addr;
        axi_ar_m.len   = len;
        axi_ar_m.burst = BURST_INCR;
        while (!axi_ar_s.ready && n < 50) begin tick(); n++; end
        if (n >= 50) check_val("ar_timeout", 32'd0, 32'd1);
        tick();
        axi_ar_m.valid = 1'b0;
        r_first = axi_r_s.valid;
        while (!done && cyc < 200) begin
            axi_r_m.ready = pat[cyc % 4];
            if (held) begin
                check_val("r_stall_data", axi_r_s.data, h_data);
                check_val("r_stall_id", {28'd0, axi_r_s.id}, {28'd0, h_id});
                check_val("r_stall_last", {31'd0, axi_r_s.last}, {31'd0, h_last});
            end
            if (axi_r_s.valid && axi_r_m.ready) begin
                if (rcount < 32) begin
                    rbuf[rcount] = axi_r_s.data;
                    rlast_mask[rcount] = axi_r_s.last;
                end
                rcount++;
                r_resp = axi_r_s.resp;
                r_id   = axi_r_s.id;
                done   = axi_r_s.last;
                held   = 1'b0;
            end else if (axi_r_s.valid) begin
                if (!held) begin
                    h_data = axi_r_s.data;
                    h_id   = axi_r_s.id;
                    h_last = axi_r_s.last;
                end
                held = 1'b1;
            end
            tick();
            cyc++;
        end
        axi_r_m.ready = 1'b0;
        if (!done) check_val("r_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        axi_aw_m = '0; axi_w_m = '0; axi_b_m = '0; axi_ar_m = '0; axi_r_m = '0;
        repeat (3) tick();
        // Reset state
        check_val("rst_awready", {31'd0, axi_aw_s.ready}, 32'd1);
        check_val("rst_arready", {31'd0, axi_ar_s.ready}, 32'd1);
        check_val("rst_wready", {31'd0, axi_w_s.ready}, 32'd0);
        check_val("rst_bvalid", {31'd0, axi_b_s.valid}, 32'd0);
        check_val("rst_rvalid", {31'd0, axi_r_s.valid}, 32'd0);
        check_val("rst_rlast", {31'd0, axi_r_s.last}, 32'd0);
        check_val("rst_ids", {24'd0, axi_b_s.id, axi_r_s.id}, 32'd0);
        check_val("rst_rdata", axi_r_s.data, 32'd0);
        check_val("rst_resps", {28'd0, axi_b_s.resp, axi_r_s.resp}, 32'd0);
        reset = 1'b1;
        tick();

        // Single write then read at 0x10
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h10, 4'd3, 8'd0, 1, 4'hF, 0);
        check_val("w1_bvalid_t2", {31'd0, b_imm}, 32'd1);
        check_val("w1_bresp", {30'd0, b_resp}, 32'd0);
        check_val("w1_bid", {28'd0, b_id}, 32'd3);
        axi_read(32'h10, 4'd5, 8'd0, 4'hF);
        check_val("r1_first", {31'd0, r_first}, 32'd1);
        check_val("r1_count", rcount, 32'd1);
        check_val("r1_data", rbuf[0], 32'hDEADBEEF);
        check_val("r1_rlast", rlast_mask, 32'h1);
        check_val("r1_rid", {28'd0, r_id}, 32'd5);
        check_val("r1_rresp", {30'd0, r_resp}, 32'd0);

        // Partial strobe merge
        wbuf[0] = 32'h11223344;
        axi_write(32'h20, 4'd1, 8'd0, 1, 4'hF, 0);
        wbuf[0] = 32'hAABBCCDD;
        axi_write(32'h20, 4'd1, 8'd0, 1, 4'h5, 0);
        axi_read(32'h20, 4'd1, 8'd0, 4'hF);
        check_val("strb_data", rbuf[0], 32'h11BB33DD);

        // Burst wrapping past the last word
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0A00000 + i;
        axi_write(32'hFF8, 4'd2, 8'd3, 4, 4'hF, 3);
        check_val("wrap_bresp", {30'd0, b_resp}, 32'd0);
        axi_read(32'hFF8, 4'd2, 8'd3, 4'hF);
        check_val("wrap_count", rcount, 32'd4);
        for (int i = 0; i < 4; i++) check_val("wrap_data", rbuf[i], 32'hA0A00000 + i);
        check_val("wrap_rlast", rlast_mask, 32'h8);
        axi_read(32'h0, 4'd2, 8'd1, 4'hF);
        check_val("wrap_w0", rbuf[0], 32'hA0A00002);
        check_val("wrap_w1", rbuf[1], 32'hA0A00003);

        // 8-beat read with RREADY pattern 1,0,0,1
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h00001000 + i;
        axi_write(32'h100, 4'd4, 8'd7, 8, 4'hF, 7);
        axi_read(32'h100, 4'd9, 8'd7, 4'b1001);
        check_val("stall_count", rcount, 32'd8);
        for (int i = 0; i < 8; i++) check_val("stall_data", rbuf[i], 32'h00001000 + i);
        check_val("stall_rlast", rlast_mask, 32'h80);
        check_val("stall_rid", {28'd0, r_id}, 32'd9);

        // WLAST on second beat of a 4-beat burst
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + i;
        axi_write(32'h200, 4'd7, 8'd3, 4, 4'hF, 1);
        check_val("wlast_b_after4", {31'd0, b_imm}, 32'd1);
        check_val("wlast_bresp", {30'd0, b_resp}, 32'd2);
        axi_read(32'h20C, 4'd0, 8'd0, 4'hF);
        check_val("wlast_beat4", rbuf[0], 32'hC0DE0003);

        // Length above the maximum: 16 beats, SLVERR
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h0BAD0000 + i;
        axi_write(32'h300, 4'd8, 8'd20, 16, 4'hF, 15);
        check_val("len_b_after16", {31'd0, b_imm}, 32'd1);
        check_val("len_bresp", {30'd0, b_resp}, 32'd2);
        axi_read(32'h300, 4'd8, 8'd20, 4'hF);
        check_val("len_rcount", rcount, 32'd16);
        check_val("len_rresp", {30'd0, r_resp}, 32'd2);
        check_val("len_rlast", rlast_mask, 32'h8000);
        check_val("len_last_data", rbuf[15], 32'h0BAD000F);

        // Same-word read and write in one cycle returns the old data
        wbuf[0] = 32'h01010101;
        axi_write(32'h30, 4'd4, 8'd0, 1, 4'hF, 0);
        send_aw(32'h30, 4'd4, 8'd0);
        axi_w_m.valid = 1'b1; axi_w_m.data = 32'h02020202; axi_w_m.strb = 4'hF; axi_w_m.last = 1'b1;
        axi_ar_m.valid = 1'b1; axi_ar_m.id = 4'd7; axi_ar_m.addr = 32'h30; axi_ar_m.len = 8'd0;
        check_val("rbw_ready", {30'd0, axi_w_s.ready, axi_ar_s.ready}, 32'd3);
        tick();
        axi_w_m.valid = 1'b0;
        axi_ar_m.valid = 1'b0;
        check_val("rbw_rvalid", {31'd0, axi_r_s.valid}, 32'd1);
        check_val("rbw_old", axi_r_s.data, 32'h01010101);
        recv_b();
        axi_r_m.ready = 1'b1;
        tick();
        axi_r_m.ready = 1'b0;
        axi_read(32'h30, 4'd7, 8'd0, 4'hF);
        check_val("rbw_new", rbuf[0], 32'h02020202);

`ifdef AXI_SRAM_BOUNDS_CHECK_EN
        axi_read(32'h80000000, 4'd3, 8'd0, 4'hF);
        check_val("bnd_rresp", {30'd0, r_resp}, 32'd3);
        check_val("bnd_rdata", rbuf[0], 32'd0);
        wbuf[0] = 32'h12345678;
        axi_write(32'h80000010, 4'd3, 8'd0, 1, 4'hF, 0);
        check_val("bnd_bresp", {30'd0, b_resp}, 32'd3);
        axi_read(32'h10, 4'd3, 8'd0, 4'hF);
        check_val("bnd_untouched", rbuf[0], 32'hDEADBEEF);
`else
        axi_read(32'h80000010, 4'd3, 8'd0, 4'hF);
        check_val("alias_rresp", {30'd0, r_resp}, 32'd0);
        check_val("alias_rdata", rbuf[0], 32'hDEADBEEF);
`endif

        // Reset during beat 2 of a 4-beat write
        send_aw(32'h400, 4'd2, 8'd3);
        send_w(32'h77770000, 4'hF, 1'b0);
        send_w(32'h77770001, 4'hF, 1'b0);
        reset = 1'b0;
        #1;
        check_val("mid_rst_bvalid", {31'd0, axi_b_s.valid}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("mid_rst_awready", {31'd0, axi_aw_s.ready}, 32'd1);
        check_val("mid_rst_bvalid2", {31'd0, axi_b_s.valid}, 32'd0);
        check_val("mid_rst_wready", {31'd0, axi_w_s.ready}, 32'd0);
        wbuf[0] = 32'h000055AA;
        axi_write(32'h400, 4'd6, 8'd0, 1, 4'hF, 0);
        check_val("post_rst_bresp", {30'd0, b_resp}, 32'd0);
        check_val("post_rst_bid", {28'd0, b_id}, 32'd6);
        axi_read(32'h400, 4'd6, 8'd0, 4'hF);
        check_val("post_rst_data", rbuf[0], 32'h000055AA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_axi_sram_sub.md
Name: riscv_axi_sram_sub

Overview:
AXI4 subordinate (responder) backing a word-addressed SRAM. It is the far end of the manager-side request driver. It accepts AR/AW/W from a manager and returns R/B responses. Read and write channels run as independent FSMs so a read and a write can be in flight together. Sits on the core's memory bus as local RAM for instruction and data traffic.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two.
ADDR_LSB, 2, byte-offset bits dropped to form the word index.
MAX_LEN, 15, largest AxLEN accepted (bursts of 1..16 beats).

Ports:
clock  input  1  single clock
reset  input  1  asynchronous, active-low reset
AXI_AW_M  input  axi4_pkg::aw_m  AWVALID/AWID/AWADDR/AWLEN/AWBURST from manager
AXI_W_M  input  axi4_pkg::w_m  WVALID/WDATA/WSTRB/WLAST
AXI_B_M  input  axi4_pkg::b_m  BREADY
AXI_AR_M  input  axi4_pkg::ar_m  ARVALID/ARID/ARADDR/ARLEN/ARBURST
AXI_R_M  input  axi4_pkg::r_m  RREADY
AXI_AW_S  output  axi4_pkg::aw_s  AWREADY
AXI_W_S  output  axi4_pkg::w_s  WREADY
AXI_B_S  output  axi4_pkg::b_s  BVALID/BID/BRESP
AXI_AR_S  output  axi4_pkg::ar_s  ARREADY
AXI_R_S  output  axi4_pkg::r_s  RVALID/RID/RDATA/RRESP/RLAST

Behaviour:
- Reset (reset=0, async): both FSMs go to IDLE. BVALID=0, RVALID=0, RLAST=0, WREADY=0, AWREADY=1, ARREADY=1. BID/RID/RDATA/BRESP/RRESP=0. Memory contents are not reset. Reset in the middle of a burst aborts it and produces no B or R.
- Word index = AxADDR[ADDR_LSB+$clog2(DEPTH)-1:ADDR_LSB]. Upper bits are ignored, so addresses wrap modulo DEPTH. AxSIZE is ignored (always 32-bit). AxBURST is treated as INCR. The index increments by 1 per beat and wraps at DEPTH-1 -> 0.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AWVALID, latch AWID, index, len=AWLEN (saturated to MAX_LEN), beat=0, then go to W_DATA.
  - W_DATA: WREADY=1, AWREADY=0. Each WVALID beat writes the byte lanes where WSTRB[i]=1, then index++ and beat++.
  - On beat==len: go to W_RESP. If WLAST != (beat==len) on any beat, latch err.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=err ? SLVERR(2'b10) : OKAY(2'b00). Hold until BREADY, then go to W_IDLE.
  - Minimum write of 1 beat: AW cycle t, W cycle t+1, BVALID at t+2.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID, latch ARID, index, len, beat=0, then go to R_DATA.
  - R_DATA: RDATA is registered. The first beat presents (RVALID=1) the cycle after the AR handshake.
  - While RREADY=1, one beat per cycle; RDATA, RID, RLAST are held stable while RVALID && !RREADY.
  - RLAST=1 on beat==len. The RLAST handshake returns to R_IDLE. RRESP=OKAY.
- Simultaneous same-word read and write in one cycle: read returns the old data (read-before-write).
- Back-to-back: a new AW (AR) is accepted the cycle after the B (last R) handshake; no overlap within a channel.
- AxLEN > MAX_LEN: the burst runs MAX_LEN+1 beats and the response carries SLVERR.

Optional Feature:
AXI_SRAM_BOUNDS_CHECK_EN:
- Defined: any AxADDR bit above the word-index range being nonzero marks the transaction as DECERR (2'b11).
  - Writes: beats are consumed, memory is untouched, BRESP=DECERR.
  - Reads: RDATA=0 on all beats, RRESP=DECERR.
- Undefined: upper bits are ignored and addresses wrap as described.

Decomposition:
- axi4_pkg gains:
  - resp_e enum: OKAY, EXOKAY, SLVERR, DECERR.
  - burst_e enum.
  - AXI_DATA_W=32 and AXI_ID_W=4 constants.
- Module-local: wr_state_e and rd_state_e.
- One sub-module, riscv_sram_1r1w: byte-enabled memory with one registered read port and one write port, read-before-write.

Test Plan:
- Single write AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF, then read ARADDR=0x10 -> BRESP=OKAY; RDATA=0xDEADBEEF, RLAST=1, RID=ARID.
- Partial strobe: word 0x20 preloaded 0x11223344, write 0xAABBCCDD with WSTRB=0x5 -> readback 0x11BB33DD.
- 4-beat burst AWLEN=3 at DEPTH*4-8 -> the last two beats land at words 0 and 1 (wrap); a 4-beat read returns the same data, RLAST only on beat 4.
- RREADY toggled 1,0,0,1 during an 8-beat read -> RDATA/RID stable while stalled, no beat lost or duplicated.
- WLAST asserted on beat 2 of AWLEN=3 -> 4 beats accepted, BRESP=SLVERR; with AXI_SRAM_BOUNDS_CHECK_EN and ARADDR=0x8000_0000 -> RRESP=DECERR, RDATA=0.
- reset driven low during beat 2 of a 4-beat write -> BVALID stays 0, AWREADY=1 after release, and the next transaction completes normally.
